// File: rtl/bus_bridge.sv
// ---------------------------------------------------------------------------
// bus_bridge
//
// Clocked bridge between two WIDTH-bit internal buses of a 6502-style
// datapath. The bridge can leave the buses unlinked, copy A onto B, copy B
// onto A, or merge them (wired-AND). Every new connection is preceded by a
// precharge phase that drives all-ones onto each destination bus. Each bus
// has a keeper that remembers the last driven value and flags a bus that
// has been floating for HOLD_CYCLES cycles. An external driver on a
// destination bus wins: the bridge backs off and records a sticky conflict.
//
// Handshake: req is a single-cycle strobe carrying mode. It is accepted
// whenever busy is low; an accepted request is answered by exactly one ack
// cycle once the requested mode is in effect (same cycle for "off", at the
// end of precharge otherwise). req while busy is high is dropped silently.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   a_in, a_drv       value on bus A / another source drives A this cycle
//   b_in, b_drv       value on bus B / another source drives B this cycle
//   mode, req         requested link (00 off, 01 A->B, 10 B->A, 11 merge)
//   ack, busy         request done pulse / precharge in progress
//   a_out, a_oe       bridge drive value and enable onto A
//   b_out, b_oe       bridge drive value and enable onto B
//   a_keep, b_keep    keeper values of A / B
//   a_stale, b_stale  bus has floated for HOLD_CYCLES cycles
//   conflict          sticky external drive on a linked destination bus
//   state_dbg         current FSM state (0 idle, 1 precharge, 2 connected)
// ---------------------------------------------------------------------------
module bus_bridge #(
    parameter int WIDTH       = 8,
    parameter int PRE_CYCLES  = 1,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    input  logic             a_drv,
    input  logic [WIDTH-1:0] b_in,
    input  logic             b_drv,
    input  logic [1:0]       mode,
    input  logic             req,
    output logic             ack,
    output logic             busy,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             a_oe,
    output logic             b_oe,
    output logic [WIDTH-1:0] a_keep,
    output logic [WIDTH-1:0] b_keep,
    output logic             a_stale,
    output logic             b_stale,
    output logic             conflict,
    output logic [1:0]       state_dbg
);

    localparam int PCW = $clog2(PRE_CYCLES + 1);
    localparam int HCW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_CONN = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [1:0]       cur_mode, mode_n;
    logic [PCW-1:0]   pre_cnt, cnt_n;
    logic             ack_n, busy_n, conflict_n;
    logic [WIDTH-1:0] a_out_n, b_out_n;
    logic             a_oe_n, b_oe_n;
    logic             hit_a, hit_b;
    logic             dest_a_cur, dest_b_cur, dest_a_n, dest_b_n;
    logic [HCW-1:0]   a_flt, b_flt;

    // Mode encoding doubles as the destination set: bit 1 targets A,
    // bit 0 targets B (merge targets both).
    assign dest_a_cur = cur_mode[1];
    assign dest_b_cur = cur_mode[0];
    assign dest_a_n   = mode_n[1];
    assign dest_b_n   = mode_n[0];

    // ---------------- next-state and next-output logic -----------------
    always_comb begin
        state_n    = state;
        mode_n     = cur_mode;
        cnt_n      = pre_cnt;
        ack_n      = 1'b0;
        conflict_n = conflict;
        hit_a      = 1'b0;
        hit_b      = 1'b0;

        case (state)
            S_IDLE: begin
                if (req) begin
                    conflict_n = 1'b0;
                    if (mode == 2'b00) begin
                        ack_n = 1'b1;
                    end else begin
                        state_n = S_PRE;
                        mode_n  = mode;
                        cnt_n   = PCW'(PRE_CYCLES - 1);
                    end
                end
            end
            S_PRE: begin
                // req is deliberately not looked at while precharging.
                hit_a = a_drv & dest_a_cur;
                hit_b = b_drv & dest_b_cur;
                if (pre_cnt == '0) begin
                    state_n = S_CONN;
                    ack_n   = 1'b1;
                end else begin
                    cnt_n = pre_cnt - PCW'(1);
                end
            end
            S_CONN: begin
                if (req) begin
                    // An accepted request wins over contention in the same
                    // cycle; the new link is checked from the next cycle on.
                    conflict_n = 1'b0;
                    if (mode == 2'b00) begin
                        state_n = S_IDLE;
                        mode_n  = 2'b00;
                        ack_n   = 1'b1;
                    end else begin
                        state_n = S_PRE;
                        mode_n  = mode;
                        cnt_n   = PCW'(PRE_CYCLES - 1);
                    end
                end else begin
                    hit_a = a_drv & dest_a_cur;
                    hit_b = b_drv & dest_b_cur;
                end
            end
            default: begin
                state_n = S_IDLE;
                mode_n  = 2'b00;
            end
        endcase

        if (hit_a | hit_b) begin
            conflict_n = 1'b1;
        end

        a_out_n = '0;
        b_out_n = '0;
        a_oe_n  = 1'b0;
        b_oe_n  = 1'b0;
        case (state_n)
            S_PRE: begin
                a_out_n = dest_a_n ? '1 : '0;
                b_out_n = dest_b_n ? '1 : '0;
                a_oe_n  = dest_a_n & ~hit_a;
                b_oe_n  = dest_b_n & ~hit_b;
            end
            S_CONN: begin
                case (mode_n)
                    2'b01:   b_out_n = a_in;
                    2'b10:   a_out_n = b_in;
                    2'b11: begin
                        // a_in/b_in already include the bridge's own
                        // previous drive, giving the wired-AND hold.
                        a_out_n = a_in & b_in;
                        b_out_n = a_in & b_in;
                    end
                    default: begin
                        a_out_n = '0;
                        b_out_n = '0;
                    end
                endcase
                a_oe_n = dest_a_n & ~hit_a;
                b_oe_n = dest_b_n & ~hit_b;
            end
            default: begin
                a_out_n = '0;
                b_out_n = '0;
            end
        endcase

        busy_n = (state_n == S_PRE);
    end

    // ---------------- FSM and output registers -------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cur_mode <= 2'b00;
            pre_cnt  <= '0;
            ack      <= 1'b0;
            busy     <= 1'b0;
            conflict <= 1'b0;
            a_out    <= '0;
            b_out    <= '0;
            a_oe     <= 1'b0;
            b_oe     <= 1'b0;
        end else begin
            state    <= state_n;
            cur_mode <= mode_n;
            pre_cnt  <= cnt_n;
            ack      <= ack_n;
            busy     <= busy_n;
            conflict <= conflict_n;
            a_out    <= a_out_n;
            b_out    <= b_out_n;
            a_oe     <= a_oe_n;
            b_oe     <= b_oe_n;
        end
    end

    // ---------------- keepers ------------------------------------------
    // A bus counts as driven when another source drives it or when the
    // bridge's registered enable is on. When the bridge is driving, the
    // keeper takes the bridge's own value.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_keep <= '1;
            b_keep <= '1;
            a_flt  <= '0;
            b_flt  <= '0;
        end else begin
            if (a_drv || a_oe) begin
                a_keep <= a_oe ? a_out : a_in;
                a_flt  <= '0;
            end else if (a_flt != HCW'(HOLD_CYCLES)) begin
                a_flt <= a_flt + HCW'(1);
            end

            if (b_drv || b_oe) begin
                b_keep <= b_oe ? b_out : b_in;
                b_flt  <= '0;
            end else if (b_flt != HCW'(HOLD_CYCLES)) begin
                b_flt <= b_flt + HCW'(1);
            end
        end
    end

    assign a_stale   = (a_flt == HCW'(HOLD_CYCLES));
    assign b_stale   = (b_flt == HCW'(HOLD_CYCLES));
    assign state_dbg = state;

endmodule

// File: tb/tb_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_bus_bridge
//
// Directed scenarios followed by a randomized run. A behavioural model of
// the bridge (link / precharge-countdown / keeper bookkeeping) runs on every
// rising edge and all outputs of the main instance are compared #1 later.
// A second instance with PRE_CYCLES=3 covers the request-during-precharge
// scenario.
// ---------------------------------------------------------------------------
module tb_bus_bridge;

    localparam int W    = 8;
    localparam int PRE  = 1;
    localparam int HOLD = 4;

    // ---------------- clock / reset / stimulus signals ------------------
    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a_in, b_in;
    logic         a_drv, b_drv;
    logic [1:0]   mode;
    logic         req;

    always #5 clk = ~clk;

    // main instance outputs
    logic         ack, busy, a_oe, b_oe, a_stale, b_stale, conflict;
    logic [W-1:0] a_out, b_out, a_keep, b_keep;
    logic [1:0]   state_dbg;

    // PRE_CYCLES=3 instance outputs
    logic         p3_ack, p3_busy, p3_a_oe, p3_b_oe, p3_a_stale, p3_b_stale, p3_conflict;
    logic [W-1:0] p3_a_out, p3_b_out, p3_a_keep, p3_b_keep;
    logic [1:0]   p3_state_dbg;

    bus_bridge #(.WIDTH(W), .PRE_CYCLES(PRE), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst),
        .a_in(a_in), .a_drv(a_drv), .b_in(b_in), .b_drv(b_drv),
        .mode(mode), .req(req),
        .ack(ack), .busy(busy),
        .a_out(a_out), .b_out(b_out), .a_oe(a_oe), .b_oe(b_oe),
        .a_keep(a_keep), .b_keep(b_keep),
        .a_stale(a_stale), .b_stale(b_stale),
        .conflict(conflict), .state_dbg(state_dbg)
    );

    bus_bridge #(.WIDTH(W), .PRE_CYCLES(3), .HOLD_CYCLES(HOLD)) dut3 (
        .clk(clk), .rst(rst),
        .a_in(a_in), .a_drv(a_drv), .b_in(b_in), .b_drv(b_drv),
        .mode(mode), .req(req),
        .ack(p3_ack), .busy(p3_busy),
        .a_out(p3_a_out), .b_out(p3_b_out), .a_oe(p3_a_oe), .b_oe(p3_b_oe),
        .a_keep(p3_a_keep), .b_keep(p3_b_keep),
        .a_stale(p3_a_stale), .b_stale(p3_b_stale),
        .conflict(p3_conflict), .state_dbg(p3_state_dbg)
    );

    // ---------------- scoreboard counters -------------------------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural reference model -----------------------
    int           m_mode;       // link being set up or in effect (0..3)
    int           m_pre_left;   // precharge cycles still to run, 0 = none
    bit           m_linked;
    bit           m_ack, m_busy, m_conflict;
    bit           m_a_oe, m_b_oe;
    logic [W-1:0] m_a_out, m_b_out, m_a_keep, m_b_keep;
    int           m_a_flt, m_b_flt;

    task automatic model_reset();
        m_mode     = 0;
        m_pre_left = 0;
        m_linked   = 0;
        m_ack      = 0;
        m_busy     = 0;
        m_conflict = 0;
        m_a_oe     = 0;
        m_b_oe     = 0;
        m_a_out    = '0;
        m_b_out    = '0;
        m_a_keep   = '1;
        m_b_keep   = '1;
        m_a_flt    = 0;
        m_b_flt    = 0;
    endtask

    task automatic model_step();
        logic [W-1:0] pa_out, pb_out;
        bit           pa_oe, pb_oe, to_a, to_b, hit_a, hit_b;
        if (rst) begin
            model_reset();
            return;
        end
        pa_out = m_a_out;
        pb_out = m_b_out;
        pa_oe  = m_a_oe;
        pb_oe  = m_b_oe;
        hit_a  = 0;
        hit_b  = 0;
        m_ack  = 0;
        to_a   = (m_mode == 2) || (m_mode == 3);
        to_b   = (m_mode == 1) || (m_mode == 3);

        if (req && m_pre_left == 0) begin
            m_conflict = 0;
            m_linked   = 0;
            if (mode == 2'd0) begin
                m_mode = 0;
                m_ack  = 1;
            end else begin
                m_mode     = int'(mode);
                m_pre_left = PRE;
            end
        end else if (m_pre_left > 0 || m_linked) begin
            hit_a = a_drv && to_a;
            hit_b = b_drv && to_b;
            if (hit_a || hit_b) m_conflict = 1;
            if (m_pre_left > 0) begin
                m_pre_left--;
                if (m_pre_left == 0) begin
                    m_linked = 1;
                    m_ack    = 1;
                end
            end
        end

        to_a    = (m_mode == 2) || (m_mode == 3);
        to_b    = (m_mode == 1) || (m_mode == 3);
        m_a_out = '0;
        m_b_out = '0;
        m_a_oe  = 0;
        m_b_oe  = 0;
        if (m_pre_left > 0) begin
            m_a_out = to_a ? '1 : '0;
            m_b_out = to_b ? '1 : '0;
            m_a_oe  = to_a && !hit_a;
            m_b_oe  = to_b && !hit_b;
        end else if (m_linked) begin
            if (m_mode == 1) m_b_out = a_in;
            if (m_mode == 2) m_a_out = b_in;
            if (m_mode == 3) begin
                m_a_out = a_in & b_in;
                m_b_out = a_in & b_in;
            end
            m_a_oe = to_a && !hit_a;
            m_b_oe = to_b && !hit_b;
        end
        m_busy = (m_pre_left > 0);

        if (a_drv || pa_oe) begin
            m_a_keep = pa_oe ? pa_out : a_in;
            m_a_flt  = 0;
        end else if (m_a_flt < HOLD) begin
            m_a_flt++;
        end
        if (b_drv || pb_oe) begin
            m_b_keep = pb_oe ? pb_out : b_in;
            m_b_flt  = 0;
        end else if (m_b_flt < HOLD) begin
            m_b_flt++;
        end
    endtask

    task automatic check_all();
        int exp_state;
        exp_state = (m_pre_left > 0) ? 1 : (m_linked ? 2 : 0);
        chk("m_state",    32'(state_dbg), 32'(exp_state));
        chk("m_ack",      32'(ack),       32'(m_ack));
        chk("m_busy",     32'(busy),      32'(m_busy));
        chk("m_conflict", 32'(conflict),  32'(m_conflict));
        chk("m_a_oe",     32'(a_oe),      32'(m_a_oe));
        chk("m_b_oe",     32'(b_oe),      32'(m_b_oe));
        chk("m_a_out",    32'(a_out),     32'(m_a_out));
        chk("m_b_out",    32'(b_out),     32'(m_b_out));
        chk("m_a_keep",   32'(a_keep),    32'(m_a_keep));
        chk("m_b_keep",   32'(b_keep),    32'(m_b_keep));
        chk("m_a_stale",  32'(a_stale),   32'(m_a_flt == HOLD));
        chk("m_b_stale",  32'(b_stale),   32'(m_b_flt == HOLD));
    endtask

    // One clock: inputs are already set; model and DUT advance on the edge,
    // outputs are compared 1 time unit later, then wait for the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        @(negedge clk);
    endtask

    // ---------------- directed + random sequence ------------------------
    initial begin
        model_reset();
        rst = 1'b1; req = 1'b0; mode = 2'd0;
        a_in = '0; b_in = '0; a_drv = 1'b0; b_drv = 1'b0;

        // Reset, then idle floating buses go stale after exactly HOLD edges.
        tick();
        chk("rst_a_oe",   32'(a_oe),      32'd0);
        chk("rst_b_oe",   32'(b_oe),      32'd0);
        chk("rst_a_keep", 32'(a_keep),    32'hFF);
        chk("rst_b_keep", 32'(b_keep),    32'hFF);
        chk("rst_state",  32'(state_dbg), 32'd0);
        rst = 1'b0;
        tick(); tick(); tick();
        chk("stale_early", 32'(a_stale), 32'd0);
        tick();
        chk("stale_a_4", 32'(a_stale), 32'd1);
        chk("stale_b_4", 32'(b_stale), 32'd1);

        // A->B link with one precharge cycle.
        a_in = 8'h3C; mode = 2'd1; req = 1'b1;
        tick();
        req = 1'b0;
        chk("ab_pre_out",  32'(b_out), 32'hFF);
        chk("ab_pre_busy", 32'(busy),  32'd1);
        chk("ab_pre_ack",  32'(ack),   32'd0);
        tick();
        chk("ab_out",  32'(b_out), 32'h3C);
        chk("ab_oe",   32'(b_oe),  32'd1);
        chk("ab_aoe",  32'(a_oe),  32'd0);
        chk("ab_ack",  32'(ack),   32'd1);
        chk("ab_busy", 32'(busy),  32'd0);
        a_in = 8'hA5;
        tick();
        chk("ab_follow", 32'(b_out), 32'hA5);
        chk("ab_ack_1w", 32'(ack),   32'd0);

        // Contention on B for two cycles.
        b_drv = 1'b1;
        tick();
        chk("cont_oe_1",  32'(b_oe),     32'd0);
        chk("cont_flag",  32'(conflict), 32'd1);
        tick();
        chk("cont_oe_2",  32'(b_oe),     32'd0);
        b_drv = 1'b0;
        tick();
        chk("cont_oe_back", 32'(b_oe),     32'd1);
        chk("cont_sticky",  32'(conflict), 32'd1);

        // Merge: new request clears conflict, then wired-AND of both buses.
        a_in = 8'hF0; b_in = 8'h3F; mode = 2'd3; req = 1'b1;
        tick();
        req = 1'b0;
        chk("mg_clr",   32'(conflict), 32'd0);
        chk("mg_pre_a", 32'(a_out),    32'hFF);
        chk("mg_pre_b", 32'(b_out),    32'hFF);
        tick();
        chk("mg_a",    32'(a_out), 32'h30);
        chk("mg_b",    32'(b_out), 32'h30);
        chk("mg_aoe",  32'(a_oe),  32'd1);
        chk("mg_boe",  32'(b_oe),  32'd1);
        chk("mg_ack",  32'(ack),   32'd1);

        // Reset while B->A is connected, then an off-request.
        mode = 2'd2; req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        chk("ba_aoe", 32'(a_oe),  32'd1);
        chk("ba_out", 32'(a_out), 32'h3F);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rc_aoe",   32'(a_oe),      32'd0);
        chk("rc_state", 32'(state_dbg), 32'd0);
        chk("rc_ack",   32'(ack),       32'd0);
        mode = 2'd0; req = 1'b1;
        tick();
        req = 1'b0;
        chk("off_ack",  32'(ack),  32'd1);
        chk("off_busy", 32'(busy), 32'd0);
        chk("off_aoe",  32'(a_oe), 32'd0);
        tick();
        chk("off_ack_1w", 32'(ack), 32'd0);

        // Disconnect from CONN takes effect after one edge.
        mode = 2'd1; req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        mode = 2'd0; req = 1'b1;
        tick();
        req = 1'b0;
        chk("disc_oe",  32'(b_oe), 32'd0);
        chk("disc_ack", 32'(ack),  32'd1);

        // PRE_CYCLES=3: request during precharge is ignored.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_in = 8'h55; mode = 2'd1; req = 1'b1;
        tick();
        req = 1'b0;
        chk("p3_busy_1", 32'(p3_busy), 32'd1);
        chk("p3_boe_1",  32'(p3_b_oe), 32'd1);
        tick();
        chk("p3_busy_2", 32'(p3_busy), 32'd1);
        mode = 2'd2; req = 1'b1;
        tick();
        req = 1'b0;
        chk("p3_busy_3", 32'(p3_busy), 32'd1);
        chk("p3_ack_3",  32'(p3_ack),  32'd0);
        tick();
        chk("p3_ack",   32'(p3_ack),   32'd1);
        chk("p3_busy",  32'(p3_busy),  32'd0);
        chk("p3_boe",   32'(p3_b_oe),  32'd1);
        chk("p3_aoe",   32'(p3_a_oe),  32'd0);
        chk("p3_bout",  32'(p3_b_out), 32'h55);
        tick();
        chk("p3_ack_1w", 32'(p3_ack), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            req   = ($urandom_range(0, 5) == 0);
            mode  = 2'($urandom_range(0, 3));
            a_in  = W'($urandom);
            b_in  = W'($urandom);
            a_drv = ($urandom_range(0, 7) == 0);
            b_drv = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bus_bridge.md
# bus_bridge

Parametrised, clocked bus bridge connecting two WIDTH-bit internal buses (e.g. special bus ↔ data bus, special bus ↔ address-high bus) in the 6502 datapath.
- Supports four link modes: off, A→B, B→A and merge (wired-AND of both buses).
- A precharge phase runs before every new connection.
- Per-bus keepers hold the last driven value and flag a bus that has floated too long.
- Drive contention on a destination bus is detected and resolved.
- External buses are modelled as separate in/drive-flag/out/oe signals, so the block is fully synchronous and synthesisable.

## Interface
Parameters:
- WIDTH, 8, bus width in bits (≥1)
- PRE_CYCLES, 1, precharge duration in cycles (≥1)
- HOLD_CYCLES, 4, floating cycles before a keeper reports stale (≥1)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- a_in  input  WIDTH  current value on bus A
- a_drv  input  1  some other source drives bus A this cycle
- b_in  input  WIDTH  current value on bus B
- b_drv  input  1  some other source drives bus B this cycle
- mode  input  2  requested link: 00 off, 01 A→B, 10 B→A, 11 merge
- req  input  1  apply mode (single-cycle strobe)
- ack  output  1  one-cycle pulse: requested mode is now in effect
- busy  output  1  high while precharging; req ignored
- a_out, b_out  output  WIDTH  bridge drive value onto A / B
- a_oe, b_oe  output  1  bridge drive enable onto A / B
- a_keep, b_keep  output  WIDTH  keeper value of A / B
- a_stale, b_stale  output  1  bus has floated for HOLD_CYCLES cycles
- conflict  output  1  sticky: destination bus driven externally while linked

## Operation
- States: IDLE (link off), PRE (precharging), CONN (linked). Mode is latched in cur_mode when req is accepted.
- Destination set: A→B: {B}; B→A: {A}; merge: {A,B}.
- IDLE:
  - req & mode≠00 → PRE. Latch mode, load precharge counter.
  - req & mode=00 → stay in IDLE, pulse ack.
- PRE:
  - Each destination: x_oe=1, x_out=all-ones.
  - busy=1; req is ignored and never acked.
  - After PRE_CYCLES cycles → CONN, pulse ack.
- CONN:
  - A→B: b_out←a_in, b_oe=1, a_oe=0.
  - B→A: mirror of A→B.
  - merge: a_out=b_out←a_in & b_in, both oe=1.
  - req & mode=00 → IDLE, pulse ack.
  - req & mode≠00 → PRE with the new mode, including re-request of the same mode.
- Contention:
  - In PRE or CONN, x_drv=1 on a destination bus forces x_oe=0 on the next cycle and sets conflict.
  - conflict clears only on an accepted req or on rst.
  - x_oe returns to 1 one cycle after x_drv falls.
- Keepers, per bus:
  - Driven means x_drv=1 or the bridge's registered x_oe=1.
  - Driven → keep loads x_in, or x_out when the bridge is the driver; float counter clears.
  - Not driven → keep holds; counter increments, saturating at HOLD_CYCLES.
  - x_stale = (counter == HOLD_CYCLES).

## Timing
- All outputs are registered. Input sampled at edge n appears on outputs after edge n (1-cycle latency).
- Connection latency: req at edge n → PRE visible after n; CONN outputs and ack after edge n+PRE_CYCLES.
- Disconnect latency: off-req at edge n → oe=0 and ack after edge n.
- ack is exactly one cycle wide; busy=1 for exactly PRE_CYCLES cycles.
- rst takes effect at the next edge and overrides everything, including mid-PRE and mid-CONN. The bridge releases both buses that cycle.
- Reset values:
  - state=IDLE
  - ack=busy=conflict=0
  - a_oe=b_oe=0, a_out=b_out=0
  - keepers all-ones, counters 0, stale=0
- Simultaneous events:
  - req together with x_drv in CONN: the req is processed and conflict is cleared, then re-evaluated against the new mode from the next cycle.
  - A stale counter at saturation with a new drive: drive wins, so counter clears and stale drops after that edge.
- Merge uses the current-cycle a_in/b_in; the bridge's own prior drive is included, which models wired-AND hold.

## Test plan
- Reset then idle: rst 1 cycle, WIDTH=8 → all oe 0, keepers 0xFF. With no drivers, a_stale=b_stale=1 after exactly 4 edges.
- A→B link: req mode=01 with a_in=0x3C, PRE_CYCLES=1 → b_out=0xFF for one cycle with busy=1, then b_out=0x3C, b_oe=1, ack pulse. A change of a_in to 0xA5 appears on b_out one cycle later.
- Merge: req mode=11, a_in=0xF0, b_in=0x3F → after PRE, a_out=b_out=0x30, both oe=1.
- Contention: A→B in CONN, b_drv=1 for 2 cycles → b_oe=0 for those 2 cycles, conflict=1 and sticky, b_oe=1 after b_drv falls. A new req clears conflict.
- Req during PRE with PRE_CYCLES=3: second req (mode=10) in cycle 2 → ignored, link ends as A→B, single ack.
- Reset mid-CONN: rst while B→A is active → next cycle a_oe=0, state IDLE, ack=0. A following req mode=00 gives an ack pulse only.
